// File: rtl/stack_sequencer.sv
// stack_sequencer: walks a push/pop register mask, issuing one stack bus cycle per set bit and tracking SP.
// Define STACK_SEQUENCER_WRAP_FAULT_EN to add the SP wrap detector on wrap_fault.
module stack_sequencer #(
    parameter int MASK_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int STEP        = 2,
    parameter int DISCARD_BIT = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      push,
    input  logic [MASK_W-1:0]         mask,
    input  logic [ADDR_W-1:0]         sp_in,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         sp_out,
    output logic                      req,
    output logic                      req_we,
    output logic [ADDR_W-1:0]         req_addr,
    output logic [$clog2(MASK_W)-1:0] req_index,
    output logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W-1:0]         wdata_in,
    input  logic                      ack,
    input  logic [DATA_W-1:0]         rdata,
    output logic                      wb_valid,
    output logic [$clog2(MASK_W)-1:0] wb_index,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      wrap_fault
);
    localparam int IW = $clog2(MASK_W);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state_q, state_d;
    logic                push_q, push_d;
    logic [MASK_W-1:0]   mask_q, mask_d, rest;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic                wb_valid_q, wb_valid_d;
    logic [IW-1:0]       wb_index_q, wb_index_d, lo, hi, sel;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                fire;

    // Push walks low-to-high, pop walks high-to-low so a pop undoes a push.
    always_comb begin
        lo = '0;
        hi = '0;
        for (int i = MASK_W - 1; i >= 0; i--) if (mask_q[i]) lo = IW'(i);
        for (int i = 0; i < MASK_W; i++) if (mask_q[i]) hi = IW'(i);
    end

    assign sel  = push_q ? lo : hi;
    assign fire = (state_q == RUN) && ack;
    assign rest = mask_q & ~(MASK_W'(1) << sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start) state_d = (|mask) ? RUN : FIN;
        else if (state_q == FIN) state_d = IDLE;
        else if (fire && rest == '0) state_d = FIN;
    end

    always_comb begin
        busy      = state_q == RUN;
        req       = state_q == RUN;
        done      = state_q == FIN;
        req_we    = req && push_q;
        req_index = req ? sel : '0;
        req_addr  = req ? (push_q ? sp_q - STEP_A : sp_q) : '0;
        req_wdata = wdata_in;
        sp_out    = sp_q;
        wb_valid  = wb_valid_q;
        wb_index  = wb_index_q;
        wb_data   = wb_data_q;
    end

    always_comb begin
        push_d = push_q;
        mask_d = mask_q;
        sp_d   = sp_q;
        if (state_q == IDLE && start) begin
            push_d = push;
            mask_d = mask;
            sp_d   = sp_in;
        end else if (fire) begin
            mask_d = rest;
            sp_d   = push_q ? sp_q - STEP_A : sp_q + STEP_A;
        end
        wb_valid_d = fire && !push_q && sel != IW'(DISCARD_BIT);
        wb_index_d = (fire && !push_q) ? sel : wb_index_q;
        wb_data_d  = (fire && !push_q) ? rdata : wb_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q     <= 1'b0;
            mask_q     <= '0;
            sp_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_index_q <= '0;
            wb_data_q  <= '0;
        end else begin
            push_q     <= push_d;
            mask_q     <= mask_d;
            sp_q       <= sp_d;
            wb_valid_q <= wb_valid_d;
            wb_index_q <= wb_index_d;
            wb_data_q  <= wb_data_d;
        end
    end

`ifdef STACK_SEQUENCER_WRAP_FAULT_EN
    logic wrap_q, wrap_d;

    // All-ones minus STEP is ~STEP, the highest SP that pops without wrapping.
    assign wrap_d = fire && (push_q ? sp_q < STEP_A : sp_q > ~STEP_A);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= wrap_d;
    end

    assign wrap_fault = wrap_q;
`else
    assign wrap_fault = 1'b0;
`endif
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed vector table plus hand-written stall/reset sequences for stack_sequencer.
module tb_stack_sequencer;
`ifdef STACK_SEQUENCER_WRAP_FAULT_EN
    localparam int WE = 1;
`else
    localparam int WE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, push, ack;
    logic [15:0] mask, sp_in, wdata_in, rdata;
    logic        busy, done, req, req_we, wb_valid, wrap_fault;
    logic [15:0] sp_out, req_addr, req_wdata, wb_data;
    logic [3:0]  req_index, wb_index;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .push(push), .mask(mask), .sp_in(sp_in),
        .busy(busy), .done(done), .sp_out(sp_out), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_index(req_index), .req_wdata(req_wdata), .wdata_in(wdata_in),
        .ack(ack), .rdata(rdata), .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .wrap_fault(wrap_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int q_addr[$], q_idx[$], q_we[$], q_wbi[$], q_wbd[$];
    int lat, nwrap;
    logic wb_at_done;
    logic [15:0] rd_tab[0:15];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Cycle 1 is the cycle start is driven; lat is the cycle number in which done is seen.
    task automatic run_seq(input logic p, input logic [15:0] m, input logic [15:0] s);
        q_addr.delete(); q_idx.delete(); q_we.delete(); q_wbi.delete(); q_wbd.delete();
        lat = 0; nwrap = 0; wb_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1; push = p; mask = m; sp_in = s; ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c < 64; c++) begin
            if (wrap_fault) nwrap++;
            if (wb_valid) begin
                q_wbi.push_back(int'(wb_index));
                q_wbd.push_back(int'(wb_data));
            end
            if (done) begin
                lat = c;
                wb_at_done = wb_valid;
                break;
            end
            if (req) begin
                q_addr.push_back(int'(req_addr));
                q_idx.push_back(int'(req_index));
                q_we.push_back(int'(req_we));
                rdata = rd_tab[q_addr.size() - 1];
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL timeout: done never seen for mask %h", m);
        end
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        ack = 1'b0;
    endtask

    typedef struct {
        logic        p;
        logic [15:0] m, s, a0, sp;
        int          i0, n, nwb, lat, wrp;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 16'h4803, 16'h0100, 16'h00FE, 16'h00F8, 0, 4, 0, 6, 0};
        vt[1] = '{1'b0, 16'h4800, 16'h00F8, 16'h00F8, 16'h00FC, 14, 2, 2, 4, 0};
        vt[2] = '{1'b0, 16'h01FF, 16'h0200, 16'h0200, 16'h0212, 8, 9, 8, 11, 0};
        vt[3] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 2, 0};
        vt[4] = '{1'b1, 16'h0020, 16'h0010, 16'h000E, 16'h000E, 5, 1, 0, 3, 0};
        vt[5] = '{1'b0, 16'h8000, 16'hFFFE, 16'hFFFE, 16'h0000, 15, 1, 1, 3, WE};
        vt[6] = '{1'b1, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 0, 1, 0, 3, WE};
        vt[7] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0020, 15, 16, 15, 18, 0};
        for (int k = 0; k < 16; k++) rd_tab[k] = 16'hD000 + 16'(k);

        reset = 1'b1; start = 1'b0; push = 1'b0; ack = 1'b0;
        mask = '0; sp_in = '0; wdata_in = '0; rdata = '0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_req", int'(req), 0);
        chk("rst_sp", int'(sp_out), 0);
        chk("rst_addr", int'(req_addr), 0);
        chk("rst_wb", int'(wb_valid), 0);
        chk("rst_wrap", int'(wrap_fault), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[v]) begin
            run_seq(vt[v].p, vt[v].m, vt[v].s);
            chk($sformatf("v%0d_nreq", v), q_addr.size(), vt[v].n);
            chk($sformatf("v%0d_nwb", v), q_wbi.size(), vt[v].nwb);
            chk($sformatf("v%0d_sp", v), int'(sp_out), int'(vt[v].sp));
            chk($sformatf("v%0d_lat", v), lat, vt[v].lat);
            chk($sformatf("v%0d_wrap", v), nwrap, vt[v].wrp);
            if (vt[v].n > 0) begin
                chk($sformatf("v%0d_addr0", v), q_addr.size() > 0 ? q_addr[0] : -1, int'(vt[v].a0));
                chk($sformatf("v%0d_idx0", v), q_idx.size() > 0 ? q_idx[0] : -1, vt[v].i0);
                chk($sformatf("v%0d_we0", v), q_we.size() > 0 ? q_we[0] : -1, int'(vt[v].p));
            end
        end

        begin
            int ea[4] = '{16'h00FE, 16'h00FC, 16'h00FA, 16'h00F8};
            int ei[4] = '{0, 1, 11, 14};
            run_seq(1'b1, 16'h4803, 16'h0100);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("push_addr%0d", i), i < q_addr.size() ? q_addr[i] : -1, ea[i]);
                chk($sformatf("push_idx%0d", i), i < q_idx.size() ? q_idx[i] : -1, ei[i]);
            end
        end

        rd_tab[0] = 16'h1234;
        rd_tab[1] = 16'hF000;
        run_seq(1'b0, 16'h4800, 16'h00F8);
        chk("pop_wbi0", q_wbi.size() > 0 ? q_wbi[0] : -1, 14);
        chk("pop_wbd0", q_wbd.size() > 0 ? q_wbd[0] : -1, 16'h1234);
        chk("pop_wbi1", q_wbi.size() > 1 ? q_wbi[1] : -1, 11);
        chk("pop_wbd1", q_wbd.size() > 1 ? q_wbd[1] : -1, 16'hF000);
        chk("pop_wb_with_done", int'(wb_at_done), 1);

        begin
            int ew[8] = '{8, 7, 6, 4, 3, 2, 1, 0};
            run_seq(1'b0, 16'h01FF, 16'h0300);
            for (int i = 0; i < 8; i++)
                chk($sformatf("pusha_wbi%0d", i), i < q_wbi.size() ? q_wbi[i] : -1, ew[i]);
        end

        @(negedge clk);
        start = 1'b1; push = 1'b1; mask = 16'h0006; sp_in = 16'h0100; ack = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_req%0d", k), int'(req), 1);
            chk($sformatf("stall_addr%0d", k), int'(req_addr), 16'h00FE);
            chk($sformatf("stall_idx%0d", k), int'(req_index), 1);
            chk($sformatf("stall_sp%0d", k), int'(sp_out), 16'h0100);
            start = (k == 0);
            mask = 16'hFFFF;
            push = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("stall_we", int'(req_we), 1);
        ack = 1'b1;
        wdata_in = 16'hBEEF;
        #1;
        chk("wdata_pass", int'(req_wdata), 16'hBEEF);
        @(negedge clk);
        ack = 1'b0;
        chk("next_idx", int'(req_index), 2);
        chk("next_addr", int'(req_addr), 16'h00FC);
        chk("next_sp", int'(sp_out), 16'h00FE);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", int'(req), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_sp", int'(sp_out), 0);
        chk("arst_idx", int'(req_index), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_req", int'(req), 0);
        chk("post_rst_done", int'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Walks a push/pop register bitmask, one set bit at a time, and issues one stack bus cycle per set bit, tracking SP.
- Sits between the decoder's push/pop masks (STACK_AW..STACK_OPERAND layout) and the bus interface / register file.
- Parametrised in mask width, address/data width and SP step, so it serves both the 16-bit mask and wider future masks.
- Adds ordering, SP arithmetic, discard handling and wrap detection.

Parameters:
- MASK_W, 16, number of mask bits; bit i is item index i.
- ADDR_W, 16, SP/address width.
- DATA_W, 16, stack data width.
- STEP, 2, bytes per stack item.
- DISCARD_BIT, 5, index whose pop performs the bus read but suppresses writeback (STACK_SP_DISCARD).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin sequence; sampled only in IDLE
- push  in  1  1 = push, 0 = pop; latched at start
- mask  in  MASK_W  items to transfer; latched at start
- sp_in  in  ADDR_W  initial SP; latched at start
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- sp_out  out  ADDR_W  current SP; final SP once done
- req  out  1  bus request valid
- req_we  out  1  1 = write (push)
- req_addr  out  ADDR_W  stack address
- req_index  out  $clog2(MASK_W)  item index of current request; also the register-file read select for push data
- req_wdata  out  DATA_W  equals wdata_in (combinational passthrough)
- wdata_in  in  DATA_W  register-file data for req_index
- ack  in  1  bus accepts request; for pops, rdata is valid this cycle
- rdata  in  DATA_W  pop read data
- wb_valid  out  1  pop writeback strobe (one cycle)
- wb_index  out  $clog2(MASK_W)  writeback destination item
- wb_data  out  DATA_W  writeback data
- wrap_fault  out  1  SP wrap detected (optional feature)

Behaviour:
Reset values:
- busy, done, req, req_we, wb_valid, wrap_fault = 0.
- sp_out, req_addr, req_index, wb_index, wb_data = 0.
- State = IDLE.

States: IDLE, RUN, FIN.

IDLE:
- On start, latch push, mask and sp_in (sp_out <= sp_in).
- Nonzero mask -> RUN. Zero mask -> FIN; no bus cycle is issued.
- busy rises the cycle after start.

Ordering:
- Push takes the lowest set bit first. Pop takes the highest set bit first, so pop mirrors push.

RUN:
- req = 1; req_index = selected bit.
- Push: req_addr = sp_out - STEP (pre-decrement, modulo 2^ADDR_W).
- Pop: req_addr = sp_out.
- req, req_addr, req_we and req_index stay stable until ack.
- On ack:
  - Clear the bit.
  - Push: sp_out <= sp_out - STEP. Pop: sp_out <= sp_out + STEP.
  - Pop only: wb_valid pulses next cycle with wb_index and wb_data = rdata captured at ack, unless the index is DISCARD_BIT.
  - Remaining mask nonzero: stay in RUN; req stays high with the next item the very next cycle (back-to-back).
  - Remaining mask zero: go to FIN.

FIN:
- done = 1 for exactly one cycle, busy = 0, req = 0, then IDLE.
- The final wb_valid coincides with done.

Latency:
- N set bits with zero-wait ack take N+2 cycles from start to done.
- Empty mask: done two cycles after start.

Boundary conditions:
- start while busy: ignored.
- ack while req = 0: ignored.
- Mask bit DISCARD_BIT on push: treated as a normal item.
- SP arithmetic wraps modulo 2^ADDR_W.
- Reset mid-sequence: all outputs return to reset values immediately; the remaining mask is lost.

Optional Feature:
Macro STACK_SEQUENCER_WRAP_FAULT_EN.
- Defined: wrap_fault pulses for one cycle, registered with the ack, when SP crosses the boundary:
  - push with sp_out < STEP, or
  - pop with sp_out > 2^ADDR_W - 1 - STEP.
- The sequence still continues with wrapped SP.
- Undefined: wrap_fault is tied to 0 and the comparison logic is absent.

Test Plan:
- Push AW|CW|PS|PC (mask 16'h4803), sp_in 16'h0100, zero-wait ack -> writes to 00FE/00FC/00FA/00F8 with indices 0,1,11,14; done at cycle 6; sp_out 16'h00F8.
- Pop mask 16'h4800, sp_in 16'h00F8, rdata 16'h1234 then 16'hF000 -> wb (14, 1234) then (11, F000); sp_out 16'h00FC.
- Pop PUSHA-style mask 16'h01FF with bit 5 set -> nine reads, eight wb_valid pulses, none for index 5; sp_out = sp_in + 18.
- Mask 0 -> no req; done two cycles after start; sp_out = sp_in.
- ack held low for 3 cycles -> req/addr/index stable; start pulsed mid-sequence is ignored; async reset during RUN drops req the same cycle.
- With STACK_SEQUENCER_WRAP_FAULT_EN defined: push with sp_in 16'h0001 -> req_addr 16'hFFFF, wrap_fault pulses once.
